// File: rtl/jalr_issue_hs_pkg.sv
// -----------------------------------------------------------------------------
// jalr_issue_hs_pkg
//   Shared definitions for the jump issue stage: default rename/depth
//   parameters, selection-policy encoding, entry and packet widths, and the
//   bit offsets of every field in both formats.
//
//   Issue entry (MSB first):
//      {is_jal, is_jalr, pc[63:0], rd0[TW-1:0], rs1[TW-1:0], is_rvc}
//   Execute packet (MSB first):
//      {is_jal, is_jalr, rd0[TW-1:0], src1[63:0], pc[63:0], is_rvc}
//   where TW = 5 + RB is the physical tag width.  A tag is
//   {architectural index[4:0], rename copy[RB-1:0]}.
// -----------------------------------------------------------------------------
package jalr_issue_hs_pkg;

   localparam int RB_DEF = 2;
   localparam int RP_DEF = 4;
   localparam int DP_DEF = 4;

   typedef enum int {
      SEL_FIXED = 0,
      SEL_RR    = 1
   } sel_mode_e;

   function automatic int tag_w(input int rb);
      return 5 + rb;
   endfunction

   function automatic int entry_w(input int rb);
      return 2 + 64 + 2 * tag_w(rb) + 1;
   endfunction

   function automatic int exe_w(input int rb);
      return 2 + tag_w(rb) + 64 + 64 + 1;
   endfunction

   // Issue-entry field offsets (LSB of each field)
   localparam int ENT_RVC = 0;
   localparam int ENT_RS1 = 1;

   function automatic int ent_rd0(input int rb);
      return 1 + tag_w(rb);
   endfunction

   function automatic int ent_pc(input int rb);
      return 1 + 2 * tag_w(rb);
   endfunction

   function automatic int ent_jalr(input int rb);
      return 65 + 2 * tag_w(rb);
   endfunction

   function automatic int ent_jal(input int rb);
      return 66 + 2 * tag_w(rb);
   endfunction

   // Execute-packet field offsets (LSB of each field)
   localparam int EXE_RVC  = 0;
   localparam int EXE_PC   = 1;
   localparam int EXE_SRC1 = 65;
   localparam int EXE_RD0  = 129;

   function automatic int exe_jalr(input int rb);
      return 129 + tag_w(rb);
   endfunction

   function automatic int exe_jal(input int rb);
      return 130 + tag_w(rb);
   endfunction

endpackage

// File: rtl/jalr_issue_hs_rr_lzp.sv
// -----------------------------------------------------------------------------
// rr_lzp
//   Wrap-around priority finder.  Scans in_i upward starting at start_i,
//   wrapping from N-1 back to 0, and reports the first set position.
//   With start_i tied to zero it is a plain lowest-index-first finder.
//
//   Ports
//      in_i     request vector
//      start_i  first index to examine
//      pos_o    index of the first set bit found (0 when none_o is set)
//      none_o   no bit of in_i is set
// -----------------------------------------------------------------------------
module rr_lzp #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  in_i,
   input  logic [IW-1:0] start_i,
   output logic [IW-1:0] pos_o,
   output logic          none_o
);

   logic [IW-1:0] idx;
   logic          found;

   // N is a power of two, so the IW-bit add wraps at N-1 by itself.
   always_comb begin
      pos_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = start_i + IW'(k);
         if (!found && in_i[idx]) begin
            pos_o = idx;
            found = 1'b1;
         end
      end
      none_o = ~found;
   end

endmodule

// File: rtl/jalr_issue_hs.sv
// -----------------------------------------------------------------------------
// jalr_issue_hs
//   Jump issue stage between the jump issue buffer and the jump execute unit.
//   Each cycle it picks one entry whose operands are ready (JAL always,
//   JALR once rs1 is written back or rs1 is x0), reads rs1 from the flat
//   register file and registers the execute packet.  Valid/ready handshake
//   toward execute, pipeline flush, and fixed or round-robin selection.
//
//   Ports
//      CLK, RST               clock, synchronous active-high reset
//      flush                  drop the held packet and block popping
//      jal_buffer_malloc      per-entry valid flag
//      jal_issue_info         DP packed issue entries, entry i at [i*DW +: DW]
//      jal_buffer_pop         pop strobe to the buffer (combinational)
//      jal_buffer_pop_index   index being popped (meaningful only with pop)
//      regFileX_read          flat register file, tag t at [64*t +: 64]
//      wbLog_qout             written-back flag per physical tag
//      jal_exe_ready          execute can take a packet
//      jal_exe_valid          packet valid (registered)
//      jal_exe_param          packet (registered)
//
//   RP is expected to equal 2**RB so every tag addresses a real
//   register-file entry.
// -----------------------------------------------------------------------------
module jalr_issue_hs
   import jalr_issue_hs_pkg::*;
#(
   parameter int RB       = RB_DEF,
   parameter int DP       = DP_DEF,
   parameter int RP       = RP_DEF,
   parameter int SEL_MODE = SEL_FIXED,
   parameter int DW       = entry_w(RB),
   parameter int EXE_DW   = exe_w(RB)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   flush,
   input  logic [DP-1:0]          jal_buffer_malloc,
   input  logic [DW*DP-1:0]       jal_issue_info,
   output logic                   jal_buffer_pop,
   output logic [$clog2(DP)-1:0]  jal_buffer_pop_index,
   input  logic [64*32*RP-1:0]    regFileX_read,
   input  logic [32*RP-1:0]       wbLog_qout,
   input  logic                   jal_exe_ready,
   output logic                   jal_exe_valid,
   output logic [EXE_DW-1:0]      jal_exe_param
);

   localparam int TW = tag_w(RB);
   localparam int IW = $clog2(DP);

   localparam int E_RD0  = ent_rd0(RB);
   localparam int E_PC   = ent_pc(RB);
   localparam int E_JALR = ent_jalr(RB);
   localparam int E_JAL  = ent_jal(RB);

   logic [DP-1:0]     clear;
   logic [IW-1:0]     sel_idx;
   logic [IW-1:0]     sel_start;
   logic              none_clear;
   logic              slot_free;
   logic              pop;

   logic [DW-1:0]     sel_ent;
   logic [TW-1:0]     sel_tag;
   logic [63:0]       sel_src1;
   logic [EXE_DW-1:0] sel_pkt;

   logic              exe_valid_q, exe_valid_d;
   logic [EXE_DW-1:0] exe_param_q, exe_param_d;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d;

   // Readiness per entry.  An entry carrying neither jump flag never clears.
   for (genvar g = 0; g < DP; g++) begin : g_ent
      logic [TW-1:0] rs1_tag;
      logic          is_jal;
      logic          is_jalr;
      logic          rs1_ready;

      assign rs1_tag   = jal_issue_info[g*DW + ENT_RS1 +: TW];
      assign is_jal    = jal_issue_info[g*DW + E_JAL];
      assign is_jalr   = jal_issue_info[g*DW + E_JALR];
      assign rs1_ready = wbLog_qout[rs1_tag] | (rs1_tag[TW-1:RB] == 5'd0);
      assign clear[g]  = jal_buffer_malloc[g] & (is_jal | (is_jalr & rs1_ready));
   end

   assign sel_start = (SEL_MODE == SEL_RR) ? rr_ptr_q : '0;

   rr_lzp #(
      .N  (DP),
      .IW (IW)
   ) u_rr_lzp (
      .in_i    (clear),
      .start_i (sel_start),
      .pos_o   (sel_idx),
      .none_o  (none_clear)
   );

   assign slot_free = ~exe_valid_q | jal_exe_ready;
   assign pop       = ~none_clear & slot_free & ~flush & ~RST;

   assign jal_buffer_pop       = pop;
   assign jal_buffer_pop_index = sel_idx;

   // Packet for the selected entry; x0 always reads as zero.
   assign sel_ent = jal_issue_info[int'(sel_idx)*DW +: DW];
   assign sel_tag = sel_ent[ENT_RS1 +: TW];

   always_comb begin
      sel_src1 = 64'h0;
      if (sel_tag[TW-1:RB] != 5'd0) begin
         sel_src1 = regFileX_read[int'(sel_tag)*64 +: 64];
      end
   end

   assign sel_pkt = {sel_ent[E_JAL],
                     sel_ent[E_JALR],
                     sel_ent[E_RD0 +: TW],
                     sel_src1,
                     sel_ent[E_PC +: 64],
                     sel_ent[ENT_RVC]};

   // Flush wins over pop; a pop that coincides with an accept replaces the
   // outgoing packet on the same edge so back-to-back issue has no bubble.
   always_comb begin
      exe_valid_d = exe_valid_q;
      exe_param_d = exe_param_q;
      rr_ptr_d    = rr_ptr_q;
      if (flush) begin
         exe_valid_d = 1'b0;
      end else if (pop) begin
         exe_valid_d = 1'b1;
         exe_param_d = sel_pkt;
         if (SEL_MODE == SEL_RR) begin
            rr_ptr_d = sel_idx + IW'(1);
         end
      end else if (jal_exe_ready && exe_valid_q) begin
         exe_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         exe_valid_q <= 1'b0;
         exe_param_q <= '0;
         rr_ptr_q    <= '0;
      end else begin
         exe_valid_q <= exe_valid_d;
         exe_param_q <= exe_param_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign jal_exe_valid = exe_valid_q;
   assign jal_exe_param = exe_param_q;

endmodule
